axi4_lite_reg_slave: RTL and testbench

AXI4-Lite responder terminating the AXI4-Lite bus driven by the team's AXI4-Lite master BFM and CPU-side interconnect. Implements a bank of NUM_REGS read/write control registers with byte-strobe writes, independent write address/data acceptance, and OKAY/SLVERR responses. Register contents are exported flat to fabric logic, with a one-cycle write pulse per register.

---
 rtl/axi4_lite_pkg.sv | 15 +
 rtl/axi4_lite_if.sv | 47 ++++
 rtl/axi4_lite_regfile.sv | 70 +++++++
 rtl/axi4_lite_reg_slave.sv | 161 ++++++++++++++++
 tb/tb_axi4_lite_reg_slave.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_lite_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_lite_pkg
//  Purpose  : Shared AXI4-Lite response encodings and types.
//  Revision : 1.0 - initial release
// ============================================================================
package axi4_lite_pkg;

   typedef logic [1:0] axi_resp_t;

   localparam axi_resp_t AXI_RESP_OKAY   = 2'b00;
   localparam axi_resp_t AXI_RESP_SLVERR = 2'b10;

endpackage
`default_nettype wire

// File: rtl/axi4_lite_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_lite_if
//  Purpose  : AXI4-Lite bus bundle with master and slave views.
//  Revision : 1.0 - initial release
// ============================================================================
interface axi4_lite_if
   import axi4_lite_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) ();

   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   axi_resp_t               bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   axi_resp_t               rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

endinterface
`default_nettype wire

// File: rtl/axi4_lite_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_lite_regfile
//  Purpose  : NUM_REGS byte-strobed registers, per-register write pulse,
//             combinational read mux and flat export of all contents.
//  Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_regfile #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 16,
   parameter int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           i_wr_en,
   input  logic [IDX_W-1:0]               i_wr_idx,
   input  logic [DATA_WIDTH-1:0]          i_wr_data,
   input  logic [DATA_WIDTH/8-1:0]        i_wr_strb,
   input  logic [IDX_W-1:0]               i_rd_idx,
   output logic [DATA_WIDTH-1:0]          o_rd_data,
   output logic [NUM_REGS*DATA_WIDTH-1:0] o_reg_q,
   output logic [NUM_REGS-1:0]            o_reg_wr_pulse
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];
   logic [NUM_REGS-1:0]   r_pulse;

   // Byte-lane update of the addressed register; the pulse only fires when
   // at least one byte actually changes hands.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_mem[i] <= '0;
         end
         r_pulse <= '0;
      end else begin
         r_pulse <= '0;
         if (i_wr_en) begin
            for (int k = 0; k < STRB_WIDTH; k++) begin
               if (i_wr_strb[k]) begin
                  r_mem[i_wr_idx][8*k +: 8] <= i_wr_data[8*k +: 8];
               end
            end
            r_pulse[i_wr_idx] <= |i_wr_strb;
         end
      end
   end

   // Read mux over stored values; an index past the bank reads as zero.
   always_comb begin
      o_rd_data = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (i_rd_idx == IDX_W'(i)) begin
            o_rd_data = r_mem[i];
         end
      end
   end

   generate
      for (genvar i = 0; i < NUM_REGS; i++) begin : g_export
         assign o_reg_q[i*DATA_WIDTH +: DATA_WIDTH] = r_mem[i];
      end
   endgenerate

   assign o_reg_wr_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/axi4_lite_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_lite_reg_slave
//  Purpose  : AXI4-Lite responder for a bank of NUM_REGS control registers.
//             AW and W are accepted independently and commit together;
//             reads are registered one cycle after the AR handshake.
//  Options  : AXI4_LITE_REG_SLAVE_SLVERR_EN - out-of-range accesses answer
//             SLVERR instead of OKAY.
//  Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_reg_slave
   import axi4_lite_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 16
) (
   input  logic                           clock,
   input  logic                           reset,
   axi4_lite_if.slave                     bus,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
   output logic [NUM_REGS-1:0]            reg_wr_pulse
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
   localparam int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

`ifdef AXI4_LITE_REG_SLAVE_SLVERR_EN
   localparam axi_resp_t c_oor_resp = AXI_RESP_SLVERR;
`else
   localparam axi_resp_t c_oor_resp = AXI_RESP_OKAY;
`endif

   logic                  r_aw_held;
   logic                  r_w_held;
   logic [ADDR_WIDTH-1:0] r_aw_addr;
   logic [DATA_WIDTH-1:0] r_w_data;
   logic [STRB_WIDTH-1:0] r_w_strb;
   logic                  r_bvalid;
   axi_resp_t             r_bresp;
   logic                  r_rvalid;
   logic [DATA_WIDTH-1:0] r_rdata;
   axi_resp_t             r_rresp;

   logic                  w_aw_hs;
   logic                  w_w_hs;
   logic                  w_ar_hs;
   logic                  w_commit;
   logic [ADDR_WIDTH-1:0] w_wr_addr;
   logic [DATA_WIDTH-1:0] w_wr_data;
   logic [STRB_WIDTH-1:0] w_wr_strb;
   logic [63:0]           w_wr_word;
   logic [63:0]           w_rd_word;
   logic                  w_wr_in_range;
   logic                  w_rd_in_range;
   logic [DATA_WIDTH-1:0] w_rd_data;
   logic                  w_unused;

   // Ready is held low during reset and while a response is outstanding.
   assign bus.awready = !reset && !r_aw_held && !r_bvalid;
   assign bus.wready  = !reset && !r_w_held  && !r_bvalid;
   assign bus.arready = !reset && !r_rvalid;

   assign w_aw_hs = bus.awvalid && bus.awready;
   assign w_w_hs  = bus.wvalid  && bus.wready;
   assign w_ar_hs = bus.arvalid && bus.arready;

   // Commit on the edge where the second of the two write halves arrives.
   assign w_commit = (w_aw_hs || w_w_hs)
                   && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

   assign w_wr_addr = r_aw_held ? r_aw_addr : bus.awaddr;
   assign w_wr_data = r_w_held  ? r_w_data  : bus.wdata;
   assign w_wr_strb = r_w_held  ? r_w_strb  : bus.wstrb;

   // Word index widened to 64 bits so the range test never truncates.
   assign w_wr_word     = 64'(w_wr_addr >> ADDR_LSB);
   assign w_rd_word     = 64'(bus.araddr >> ADDR_LSB);
   assign w_wr_in_range = w_wr_word < 64'(NUM_REGS);
   assign w_rd_in_range = w_rd_word < 64'(NUM_REGS);

   // Protection attributes carry no meaning for this register bank.
   assign w_unused = ^{bus.awprot, bus.arprot};

   axi4_lite_regfile #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .IDX_W      (IDX_W)
   ) u_regfile (
      .clock          (clock),
      .reset          (reset),
      .i_wr_en        (w_commit && w_wr_in_range),
      .i_wr_idx       (w_wr_word[IDX_W-1:0]),
      .i_wr_data      (w_wr_data),
      .i_wr_strb      (w_wr_strb),
      .i_rd_idx       (w_rd_word[IDX_W-1:0]),
      .o_rd_data      (w_rd_data),
      .o_reg_q        (reg_q),
      .o_reg_wr_pulse (reg_wr_pulse)
   );

   // Write channel: hold whichever half arrives first, respond on commit.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_aw_addr <= '0;
         r_w_data  <= '0;
         r_w_strb  <= '0;
         r_bvalid  <= 1'b0;
         r_bresp   <= AXI_RESP_OKAY;
      end else begin
         if (r_bvalid && bus.bready) begin
            r_bvalid <= 1'b0;
         end
         if (w_commit) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_wr_in_range ? AXI_RESP_OKAY : c_oor_resp;
         end else begin
            if (w_aw_hs) begin
               r_aw_held <= 1'b1;
               r_aw_addr <= bus.awaddr;
            end
            if (w_w_hs) begin
               r_w_held <= 1'b1;
               r_w_data <= bus.wdata;
               r_w_strb <= bus.wstrb;
            end
         end
      end
   end

   // Read channel: capture pre-write register contents on the AR handshake.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_rresp  <= AXI_RESP_OKAY;
      end else begin
         if (r_rvalid && bus.rready) begin
            r_rvalid <= 1'b0;
         end
         if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_in_range ? w_rd_data : '0;
            r_rresp  <= w_rd_in_range ? AXI_RESP_OKAY : c_oor_resp;
         end
      end
   end

   assign bus.bvalid = r_bvalid;
   assign bus.bresp  = r_bresp;
   assign bus.rvalid = r_rvalid;
   assign bus.rdata  = r_rdata;
   assign bus.rresp  = r_rresp;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi4_lite_reg_slave
//  Purpose  : Self-checking bench for axi4_lite_reg_slave with directed and
//             randomized AXI4-Lite traffic against a register-array model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_reg_slave;
   import axi4_lite_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NR = 16;

   typedef logic [NR*DW-1:0] val_t;

`ifdef AXI4_LITE_REG_SLAVE_SLVERR_EN
   localparam axi_resp_t c_oor = AXI_RESP_SLVERR;
`else
   localparam axi_resp_t c_oor = AXI_RESP_OKAY;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axi4_lite_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   logic [NR*DW-1:0] reg_q;
   logic [NR-1:0]    reg_wr_pulse;

   axi4_lite_reg_slave #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .NUM_REGS   (NR)
   ) dut (
      .clock        (clk),
      .reset        (rst),
      .bus          (bus),
      .reg_q        (reg_q),
      .reg_wr_pulse (reg_wr_pulse)
   );

   int n_checks = 0;
   int n_fails  = 0;
   logic [DW-1:0] model [NR];

   task automatic check_value(input string tag, input val_t got, input val_t exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic val_t model_q();
      val_t v;
      for (int i = 0; i < NR; i++) v[i*DW +: DW] = model[i];
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [3:0] strb, input int aw_start,
                            input int w_start, input int b_delay);
      bit            aw_done = 1'b0;
      bit            w_done  = 1'b0;
      int            cyc     = 0;
      int unsigned   idx     = int'(addr >> 2);
      axi_resp_t     exp_resp;
      logic [NR-1:0] exp_pulse;
      bus.awaddr = addr;
      bus.awprot = 3'($urandom);
      bus.wdata  = data;
      bus.wstrb  = strb;
      bus.bready = 1'b0;
      while (!(aw_done && w_done) && cyc < 40) begin
         bus.awvalid = !aw_done && (cyc >= aw_start);
         bus.wvalid  = !w_done  && (cyc >= w_start);
         check_value("awready_wr", val_t'(bus.awready), val_t'(!aw_done));
         check_value("wready_wr",  val_t'(bus.wready),  val_t'(!w_done));
         if (bus.awvalid && bus.awready) aw_done = 1'b1;
         if (bus.wvalid && bus.wready)   w_done  = 1'b1;
         tick();
         cyc++;
      end
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      if (!(aw_done && w_done)) check_value("write_timeout", val_t'(0), val_t'(1));
      exp_pulse = '0;
      if (idx < NR) begin
         for (int k = 0; k < 4; k++) begin
            if (strb[k]) model[idx][8*k +: 8] = data[8*k +: 8];
         end
         if (strb != 4'h0) exp_pulse[idx] = 1'b1;
         exp_resp = AXI_RESP_OKAY;
      end else begin
         exp_resp = c_oor;
      end
      check_value("bvalid_set", val_t'(bus.bvalid), val_t'(1));
      check_value("bresp", val_t'(bus.bresp), val_t'(exp_resp));
      check_value("wr_pulse", val_t'(reg_wr_pulse), val_t'(exp_pulse));
      check_value("reg_q_wr", reg_q, model_q());
      for (int d = 0; d < b_delay; d++) begin
         tick();
         check_value("bvalid_hold", val_t'(bus.bvalid), val_t'(1));
         check_value("bresp_hold", val_t'(bus.bresp), val_t'(exp_resp));
         check_value("awready_bp", val_t'(bus.awready), val_t'(0));
         check_value("wready_bp", val_t'(bus.wready), val_t'(0));
         check_value("pulse_once", val_t'(reg_wr_pulse), val_t'(0));
      end
      bus.bready = 1'b1;
      tick();
      check_value("bvalid_clr", val_t'(bus.bvalid), val_t'(0));
      bus.bready = 1'b0;
   endtask

   task automatic axi_read(input logic [AW-1:0] addr, input int r_delay);
      int unsigned   idx = int'(addr >> 2);
      logic [DW-1:0] exp_d;
      axi_resp_t     exp_r;
      if (idx < NR) begin
         exp_d = model[idx];
         exp_r = AXI_RESP_OKAY;
      end else begin
         exp_d = '0;
         exp_r = c_oor;
      end
      bus.araddr  = addr;
      bus.arprot  = 3'($urandom);
      bus.arvalid = 1'b1;
      bus.rready  = 1'b0;
      check_value("arready_idle", val_t'(bus.arready), val_t'(1));
      tick();
      bus.arvalid = 1'b0;
      check_value("rvalid_set", val_t'(bus.rvalid), val_t'(1));
      check_value("rdata", val_t'(bus.rdata), val_t'(exp_d));
      check_value("rresp", val_t'(bus.rresp), val_t'(exp_r));
      for (int d = 0; d < r_delay; d++) begin
         tick();
         check_value("rvalid_hold", val_t'(bus.rvalid), val_t'(1));
         check_value("rdata_hold", val_t'(bus.rdata), val_t'(exp_d));
         check_value("rresp_hold", val_t'(bus.rresp), val_t'(exp_r));
         check_value("arready_bp", val_t'(bus.arready), val_t'(0));
      end
      bus.rready = 1'b1;
      tick();
      check_value("rvalid_clr", val_t'(bus.rvalid), val_t'(0));
      bus.rready = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] old_v;
      logic [DW-1:0] new_v;
      bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
      bus.wdata  = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0; bus.bready = 1'b0;
      bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
      for (int i = 0; i < NR; i++) model[i] = '0;

      // Reset behaviour
      repeat (3) @(posedge clk);
      #1;
      check_value("awready_rst", val_t'(bus.awready), val_t'(0));
      check_value("wready_rst", val_t'(bus.wready), val_t'(0));
      check_value("arready_rst", val_t'(bus.arready), val_t'(0));
      check_value("bvalid_rst", val_t'(bus.bvalid), val_t'(0));
      check_value("rvalid_rst", val_t'(bus.rvalid), val_t'(0));
      check_value("reg_q_rst", reg_q, val_t'(0));
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_value("awready_rel", val_t'(bus.awready), val_t'(1));
      check_value("wready_rel", val_t'(bus.wready), val_t'(1));
      check_value("arready_rel", val_t'(bus.arready), val_t'(1));
      check_value("pulse_rel", val_t'(reg_wr_pulse), val_t'(0));
      tick();
      axi_read(32'h0, 0);

      // W leads AW by three cycles
      axi_write(32'h8, 32'hDEAD_BEEF, 4'hF, 3, 0, 0);
      check_value("reg2_const", val_t'(reg_q[2*DW +: DW]), val_t'(32'hDEAD_BEEF));
      axi_read(32'h8, 0);

      // Partial strobe
      axi_write(32'h4, 32'h1122_3344, 4'hF, 0, 0, 0);
      axi_write(32'h4, 32'hAABB_CCDD, 4'h5, 1, 0, 0);
      check_value("reg1_const", val_t'(reg_q[DW +: DW]), val_t'(32'h11BB_33DD));
      axi_read(32'h4, 0);

      // Zero strobe and backpressure
      axi_write(32'hC, 32'h0BAD_F00D, 4'h0, 0, 0, 1);
      axi_write(32'hC, $urandom, 4'hF, 0, 2, 5);
      axi_read(32'hC, 5);

      // Out of range
      axi_write(32'(NR*4), 32'hFFFF_FFFF, 4'hF, 0, 0, 2);
      axi_read(32'(NR*4), 2);

      // Read and write of register 3 meet at the same edge
      old_v = model[3];
      new_v = ~old_v;
      bus.awaddr = 32'hC; bus.wdata = new_v; bus.wstrb = 4'hF; bus.araddr = 32'hC;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
      tick();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
      model[3] = new_v;
      check_value("coll_rdata", val_t'(bus.rdata), val_t'(old_v));
      check_value("coll_bvalid", val_t'(bus.bvalid), val_t'(1));
      check_value("coll_reg_q", reg_q, model_q());
      check_value("coll_pulse", val_t'(reg_wr_pulse), val_t'(16'h0008));
      bus.bready = 1'b1; bus.rready = 1'b1;
      tick();
      check_value("coll_bclr", val_t'(bus.bvalid), val_t'(0));
      check_value("coll_rclr", val_t'(bus.rvalid), val_t'(0));
      bus.bready = 1'b0; bus.rready = 1'b0;

      // Randomized traffic
      for (int n = 0; n < 80; n++) begin
         logic [AW-1:0] a;
         a = AW'($urandom_range(0, NR + 1) * 4 + $urandom_range(0, 3));
         if ($urandom_range(0, 1) == 0)
            axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3));
         else
            axi_read(a, $urandom_range(0, 3));
      end

      // Reset while a write response is pending
      bus.awaddr = 32'h14; bus.wdata = $urandom; bus.wstrb = 4'hF;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      tick();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      check_value("pre_rst_bvalid", val_t'(bus.bvalid), val_t'(1));
      rst = 1'b1;
      #1;
      for (int i = 0; i < NR; i++) model[i] = '0;
      check_value("mid_rst_bvalid", val_t'(bus.bvalid), val_t'(0));
      check_value("mid_rst_reg_q", reg_q, model_q());
      check_value("mid_rst_awready", val_t'(bus.awready), val_t'(0));
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Address-only half write is dropped by reset
      bus.awaddr = 32'h18; bus.awvalid = 1'b1;
      tick();
      bus.awvalid = 1'b0;
      check_value("half_aw_held", val_t'(bus.awready), val_t'(0));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tick();
      new_v = $urandom;
      bus.wdata = new_v; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
      check_value("half_awready", val_t'(bus.awready), val_t'(1));
      tick();
      bus.wvalid = 1'b0;
      tick();
      check_value("half_no_resp", val_t'(bus.bvalid), val_t'(0));
      bus.awaddr = 32'h1C; bus.awvalid = 1'b1;
      tick();
      bus.awvalid = 1'b0;
      model[7] = new_v;
      check_value("half_bvalid", val_t'(bus.bvalid), val_t'(1));
      check_value("half_reg_q", reg_q, model_q());
      bus.bready = 1'b1;
      tick();
      bus.bready = 1'b0;
      axi_read(32'h18, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=1 exp=0");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
